// File: rtl/fir_pkg.sv
// Shared widths, constants and helper functions for the FIR output summer.
package fir_pkg;

    localparam int DEF_IN_W  = 16;
    localparam int DEF_OUT_W = 16;

    // Smallest r with 2^r >= v.
    function automatic int clog2(input int v);
        int r;
        int p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p * 2;
            r = r + 1;
        end
        return r;
    endfunction

    // Number of operands entering tree level lvl when the tree starts with n.
    function automatic int levelCount(input int n, input int lvl);
        int c;
        c = n;
        for (int i = 0; i < lvl; i++) begin
            c = (c + 1) / 2;
        end
        return c;
    endfunction

    // Largest value representable in a signed word of w bits.
    function automatic logic signed [63:0] satMax(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Smallest value representable in a signed word of w bits.
    function automatic logic signed [63:0] satMin(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    // Clamp v into the signed range of a w-bit word.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
        if (v > satMax(w)) begin
            return satMax(w);
        end
        if (v < satMin(w)) begin
            return satMin(w);
        end
        return v;
    endfunction

    // Rounding bias added ahead of the arithmetic shift (round half up).
    function automatic logic signed [63:0] roundConst(input int shift, input int round);
        if (round != 0 && shift > 0) begin
            return 64'sd1 <<< (shift - 1);
        end
        return 64'sd0;
    endfunction

endpackage

// File: rtl/fir_add_stage.sv
// One registered level of the summing tree: pairs of operands are added at
// one bit of growth; an unpaired last operand is sign-extended and registered.
module fir_add_stage #(
    parameter int N_OPS = 4,
    parameter int OP_W  = 16
) (
    input  logic                                    iClk_12M,
    input  logic                                    iRst,
    input  logic                                    opValid,
    input  logic [N_OPS*OP_W-1:0]                   opBus,
    output logic [((N_OPS+1)/2)*(OP_W+1)-1:0]       sumBus,
    output logic                                    sumValid
);

    localparam int N_OUT = (N_OPS + 1) / 2;

    logic [N_OUT*(OP_W+1)-1:0] sumsNext;

    for (genvar k = 0; k < N_OUT; k++) begin : gPair
        logic [OP_W-1:0] opA;
        assign opA = opBus[2*k*OP_W +: OP_W];
        if (2*k + 1 < N_OPS) begin : gAdd
            logic [OP_W-1:0] opB;
            assign opB = opBus[(2*k+1)*OP_W +: OP_W];
            assign sumsNext[k*(OP_W+1) +: OP_W+1] = {opA[OP_W-1], opA} + {opB[OP_W-1], opB};
        end else begin : gPass
            assign sumsNext[k*(OP_W+1) +: OP_W+1] = {opA[OP_W-1], opA};
        end
    end

    // Level register: data advances every cycle, valid travels alongside.
    always_ff @(posedge iClk_12M) begin
        if (iRst) begin
            sumBus   <= '0;
            sumValid <= 1'b0;
        end else begin
            sumBus   <= sumsNext;
            sumValid <= opValid;
        end
    end

endmodule

// File: rtl/fir_sum_tree_sat.sv
// FIR output summer: registered adder tree over NUM_IN MAC partials, then a
// registered round/shift/saturate stage with clip status for the control block.
module fir_sum_tree_sat
    import fir_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int IN_W   = DEF_IN_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int SHIFT  = 0,
    parameter int ROUND  = 1,
    parameter int SAT_EN = 1,
    parameter int CNT_W  = 8
) (
    input  logic                     iClk_12M,
    input  logic                     iRst,
    input  logic                     iValid,
    input  logic [NUM_IN*IN_W-1:0]   iMacBus,
    input  logic                     iClrStat,
    output logic signed [OUT_W-1:0]  oFirOut,
    output logic                     oValid,
    output logic                     oSatPos,
    output logic                     oSatNeg,
    output logic                     oSatSticky,
    output logic [CNT_W-1:0]         oSatCnt
);

    localparam int LVL   = clog2(NUM_IN);
    localparam int SUM_W = IN_W + LVL;

    localparam logic signed [SUM_W:0] RND_ADD  = (SUM_W+1)'(roundConst(SHIFT, ROUND));
    localparam logic signed [63:0]    OUT_MAX  = satMax(OUT_W);
    localparam logic signed [63:0]    OUT_MIN  = satMin(OUT_W);
    localparam logic [CNT_W-1:0]      CNT_FULL = '1;

    for (genvar l = 0; l < LVL; l++) begin : gLvl
        localparam int N  = levelCount(NUM_IN, l);
        localparam int W  = IN_W + l;
        localparam int NO = (N + 1) / 2;

        logic [NO*(W+1)-1:0] sumBus;
        logic                vOut;

        if (l == 0) begin : gFirst
            fir_add_stage #(.N_OPS(N), .OP_W(W)) uStage (
                .iClk_12M (iClk_12M),
                .iRst     (iRst),
                .opValid  (iValid),
                .opBus    (iMacBus),
                .sumBus   (sumBus),
                .sumValid (vOut)
            );
        end else begin : gNext
            fir_add_stage #(.N_OPS(N), .OP_W(W)) uStage (
                .iClk_12M (iClk_12M),
                .iRst     (iRst),
                .opValid  (gLvl[l-1].vOut),
                .opBus    (gLvl[l-1].sumBus),
                .sumBus   (sumBus),
                .sumValid (vOut)
            );
        end
    end

    logic signed [SUM_W-1:0] sumFinal;
    logic                    vLast;
    logic signed [SUM_W:0]   sumExt;
    logic signed [SUM_W:0]   rShift;
    logic signed [63:0]      rWide;
    logic                    clipPos;
    logic                    clipNeg;
    logic                    clipEvt;
    logic [OUT_W-1:0]        outNext;

    assign sumFinal = gLvl[LVL-1].sumBus;
    assign vLast    = gLvl[LVL-1].vOut;

    // Round, shift and range-check the tree sum; the extra bit keeps the bias add exact.
    always_comb begin
        sumExt  = {sumFinal[SUM_W-1], sumFinal};
        rShift  = (sumExt + RND_ADD) >>> SHIFT;
        rWide   = {{(63-SUM_W){rShift[SUM_W]}}, rShift};
        clipPos = rWide > OUT_MAX;
        clipNeg = rWide < OUT_MIN;
        outNext = (SAT_EN != 0) ? OUT_W'(saturate(rWide, OUT_W)) : OUT_W'(rWide);
        clipEvt = vLast && (clipPos || clipNeg);
    end

    // Output register: data holds between valids, strobes and clip flags are one-cycle.
    always_ff @(posedge iClk_12M) begin
        if (iRst) begin
            oFirOut <= '0;
            oValid  <= 1'b0;
            oSatPos <= 1'b0;
            oSatNeg <= 1'b0;
        end else begin
            oValid  <= vLast;
            oSatPos <= vLast && clipPos;
            oSatNeg <= vLast && clipNeg;
            if (vLast) begin
                oFirOut <= outNext;
            end
        end
    end

    // Clip status: a clip coinciding with a clear survives as the first new event.
    always_ff @(posedge iClk_12M) begin
        if (iRst) begin
            oSatSticky <= 1'b0;
            oSatCnt    <= '0;
        end else if (clipEvt) begin
            oSatSticky <= 1'b1;
            if (iClrStat) begin
                oSatCnt <= CNT_W'(1);
            end else if (oSatCnt != CNT_FULL) begin
                oSatCnt <= oSatCnt + CNT_W'(1);
            end
        end else if (iClrStat) begin
            oSatSticky <= 1'b0;
            oSatCnt    <= '0;
        end
    end

endmodule
